// File: rtl/nvram_upload_ctrl_pkg.sv
// Shared types and constants for the NVRAM upload path between hps_io and the
// williams2 CMOS.
package joust2_nv_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      WAIT_Q  = 2'd2,
      PRESENT = 2'd3
   } rd_state_t;

   localparam logic [7:0] NV_INDEX_DEFAULT = 8'd4;
   localparam logic [3:0] NV_PAD           = 4'b0000;
   localparam logic [7:0] OOR_BYTE         = 8'hFF;

   // CMOS is 4 bits wide; the upload file carries one nibble per byte.
   function automatic logic [7:0] pad_nibble(input logic [3:0] nib);
      return {NV_PAD, nib};
   endfunction

endpackage

// File: rtl/nvram_upload_ctrl_if.sv
// hps_io ioctl file channel as seen by the NVRAM responder.
interface nvram_upload_ctrl_if;
   logic        ioctl_upload;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic [16:0] ioctl_addr;
   logic        ioctl_rd;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        ioctl_upload_req;

   modport master (
      output ioctl_upload, ioctl_download, ioctl_index, ioctl_addr, ioctl_rd,
      input  ioctl_din, ioctl_wait, ioctl_upload_req
   );

   modport slave (
      input  ioctl_upload, ioctl_download, ioctl_index, ioctl_addr, ioctl_rd,
      output ioctl_din, ioctl_wait, ioctl_upload_req
   );
endinterface

// File: rtl/nvram_upload_ctrl_dirty_timer.sv
// Tracks unsaved CMOS writes and requests an NVRAM save once the CPU has been
// quiet for REQ_DELAY cycles and no file transfer is running.
module nv_dirty_timer #(
   parameter logic [23:0] REQ_DELAY = 24'd4_800_000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic cpu_nv_we,
   input  logic sel,
   input  logic xfer_active,
   output logic upload_req
);

   logic        sel_d_r;
   logic        dirty_r;
   logic [23:0] cnt_r;
   logic        req_r;
   logic [23:0] cnt_inc_s;
   logic        sel_rise_s;

   // Saturating next count and upload-start detection.
   always_comb begin
      cnt_inc_s  = (cnt_r == REQ_DELAY) ? cnt_r : cnt_r + 24'd1;
      sel_rise_s = sel & ~sel_d_r;
   end

   // A CPU write always wins; an upload of this file means a save is already underway.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sel_d_r <= 1'b0;
         dirty_r <= 1'b0;
         cnt_r   <= 24'd0;
         req_r   <= 1'b0;
      end else begin
         sel_d_r <= sel;
         req_r   <= 1'b0;
         if (cpu_nv_we) begin
            dirty_r <= 1'b1;
            cnt_r   <= 24'd0;
         end else if (sel_rise_s) begin
            dirty_r <= 1'b0;
            cnt_r   <= 24'd0;
         end else if (dirty_r) begin
            if ((cnt_inc_s == REQ_DELAY) && !xfer_active) begin
               req_r   <= 1'b1;
               dirty_r <= 1'b0;
               cnt_r   <= 24'd0;
            end else begin
               cnt_r <= cnt_inc_s;
            end
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign upload_req = req_r;

endmodule

// File: rtl/nvram_upload_ctrl.sv
// Serves CMOS nibbles to hps_io during an NVRAM upload, stalling with
// ioctl_wait while each nibble is fetched, and raises save requests.
module nvram_upload_ctrl
   import joust2_nv_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter logic [7:0]  NV_INDEX  = NV_INDEX_DEFAULT,
   parameter int          RD_LAT    = 1,
   parameter logic [23:0] REQ_DELAY = 24'd4_800_000
) (
   input  logic              clk_sys,
   input  logic              reset,
   nvram_upload_ctrl_if.slave io,
   output logic [ADDR_W-1:0] nv_addr,
   output logic              nv_rd,
   input  logic [3:0]        nv_q,
   input  logic              cpu_nv_we,
   output logic              nv_busy
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   rd_state_t         state_r, state_nxt;
   logic [ADDR_W-1:0] addr_r, addr_nxt;
   logic [ADDR_W-1:0] nv_addr_r, nv_addr_nxt;
   logic              oor_r, oor_nxt;
   logic [1:0]        lat_r, lat_nxt;
   logic              wait_r, wait_nxt;
   logic [7:0]        din_r, din_nxt;
   logic              nv_rd_r, nv_rd_nxt;
   logic              busy_r;
   logic              sel_s;
   logic              req_s;

   assign sel_s = io.ioctl_upload & (io.ioctl_index == NV_INDEX);

   // Read FSM next state; wait drops on the same edge that presents the byte.
   always_comb begin
      state_nxt   = state_r;
      addr_nxt    = addr_r;
      nv_addr_nxt = nv_addr_r;
      oor_nxt     = oor_r;
      lat_nxt     = lat_r;
      wait_nxt    = wait_r;
      din_nxt     = din_r;
      nv_rd_nxt   = 1'b0;
      case (state_r)
         IDLE: begin
            if (io.ioctl_rd && sel_s) begin
               addr_nxt  = io.ioctl_addr[ADDR_W-1:0];
               oor_nxt   = ((io.ioctl_addr >> ADDR_W) != 17'd0);
               wait_nxt  = 1'b1;
               state_nxt = oor_nxt ? PRESENT : FETCH;
            end else begin
               state_nxt = IDLE;
            end
         end
         FETCH: begin
            nv_addr_nxt = addr_r;
            nv_rd_nxt   = 1'b1;
            lat_nxt     = 2'd0;
            state_nxt   = WAIT_Q;
         end
         WAIT_Q: begin
            if (lat_r == LAT_LAST) begin
               state_nxt = PRESENT;
            end else begin
               lat_nxt = lat_r + 2'd1;
            end
         end
         PRESENT: begin
            din_nxt   = oor_r ? OOR_BYTE : pad_nibble(nv_q);
            wait_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: begin
            wait_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r   <= IDLE;
         addr_r    <= '0;
         nv_addr_r <= '0;
         oor_r     <= 1'b0;
         lat_r     <= 2'd0;
         wait_r    <= 1'b0;
         din_r     <= 8'd0;
         nv_rd_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         addr_r    <= addr_nxt;
         nv_addr_r <= nv_addr_nxt;
         oor_r     <= oor_nxt;
         lat_r     <= lat_nxt;
         wait_r    <= wait_nxt;
         din_r     <= din_nxt;
         nv_rd_r   <= nv_rd_nxt;
         busy_r    <= sel_s;
      end
   end

   nv_dirty_timer #(
      .REQ_DELAY (REQ_DELAY)
   ) u_timer (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .cpu_nv_we   (cpu_nv_we),
      .sel         (sel_s),
      .xfer_active (io.ioctl_upload | io.ioctl_download),
      .upload_req  (req_s)
   );

   assign io.ioctl_din        = din_r;
   assign io.ioctl_wait       = wait_r;
   assign io.ioctl_upload_req = req_s;
   assign nv_addr             = nv_addr_r;
   assign nv_rd               = nv_rd_r;
   assign nv_busy             = busy_r;

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Directed bench: instance A (RD_LAT=1) for reads, save requests and the full
// sweep; instance B (RD_LAT=3) for reset during a fetch.
module tb_nvram_upload_ctrl;
   import joust2_nv_pkg::*;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic [9:0] nv_addr_a, nv_addr_b;
   logic       nv_rd_a, nv_rd_b;
   logic [3:0] nv_q_a = 4'd0;
   logic [3:0] nv_q_b = 4'd0;
   logic       cpu_we_a, cpu_we_b;
   logic       nv_busy_a, nv_busy_b;
   logic [3:0] mem [0:1023];
   logic       v1 = 1'b0, v2 = 1'b0;
   logic [9:0] a1 = 10'd0, a2 = 10'd0;

   int checks   = 0;
   int failures = 0;
   int k, n, pulses, first;

   nvram_upload_ctrl_if ifa ();
   nvram_upload_ctrl_if ifb ();

   always #5 clk_sys = ~clk_sys;

   nvram_upload_ctrl #(.ADDR_W(10), .NV_INDEX(8'd4), .RD_LAT(1), .REQ_DELAY(24'd16)) u_a (
      .clk_sys(clk_sys), .reset(reset), .io(ifa), .nv_addr(nv_addr_a), .nv_rd(nv_rd_a),
      .nv_q(nv_q_a), .cpu_nv_we(cpu_we_a), .nv_busy(nv_busy_a));

   nvram_upload_ctrl #(.ADDR_W(10), .NV_INDEX(8'd4), .RD_LAT(3), .REQ_DELAY(24'd16)) u_b (
      .clk_sys(clk_sys), .reset(reset), .io(ifb), .nv_addr(nv_addr_b), .nv_rd(nv_rd_b),
      .nv_q(nv_q_b), .cpu_nv_we(cpu_we_b), .nv_busy(nv_busy_b));

   // CMOS models: one-cycle and three-cycle read latency, output held between reads.
   always @(posedge clk_sys) begin
      if (nv_rd_a) nv_q_a <= mem[nv_addr_a];
      v1 <= nv_rd_b;
      a1 <= nv_addr_b;
      v2 <= v1;
      a2 <= a1;
      if (v2) nv_q_b <= mem[a2];
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 4'((i * 7 + 3) & 15);
      mem[5] = 4'hA;
      reset = 1'b1;
      cpu_we_a = 1'b0; cpu_we_b = 1'b0;
      ifa.ioctl_upload = 1'b0; ifa.ioctl_download = 1'b0; ifa.ioctl_index = 8'd0;
      ifa.ioctl_addr = 17'd0; ifa.ioctl_rd = 1'b0;
      ifb.ioctl_upload = 1'b0; ifb.ioctl_download = 1'b0; ifb.ioctl_index = 8'd0;
      ifb.ioctl_addr = 17'd0; ifb.ioctl_rd = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("rst_din", 32'(ifa.ioctl_din), 32'h0);
      check("rst_wait", 32'(ifa.ioctl_wait), 32'h0);
      check("rst_req", 32'(ifa.ioctl_upload_req), 32'h0);
      check("rst_busy", 32'(nv_busy_a), 32'h0);
      check("rst_nv_rd", 32'(nv_rd_a), 32'h0);
      check("rst_state", 32'(u_a.state_r), 32'(IDLE));

      // In-range read of address 5
      ifa.ioctl_upload = 1'b1; ifa.ioctl_index = 8'd4;
      tick();
      check("busy_on", 32'(nv_busy_a), 32'h1);
      ifa.ioctl_addr = 17'h005; ifa.ioctl_rd = 1'b1;
      tick();
      ifa.ioctl_rd = 1'b0;
      check("ir_wait_s1", 32'(ifa.ioctl_wait), 32'h1);
      check("ir_nvrd_s1", 32'(nv_rd_a), 32'h0);
      tick();
      check("ir_nvrd_s2", 32'(nv_rd_a), 32'h1);
      check("ir_nvaddr", 32'(nv_addr_a), 32'h5);
      check("ir_wait_s2", 32'(ifa.ioctl_wait), 32'h1);
      tick();
      check("ir_nvrd_s3", 32'(nv_rd_a), 32'h0);
      check("ir_wait_s3", 32'(ifa.ioctl_wait), 32'h1);
      tick();
      check("ir_wait_s4", 32'(ifa.ioctl_wait), 32'h0);
      check("ir_din", 32'(ifa.ioctl_din), 32'h0A);

      // Out-of-range read
      ifa.ioctl_addr = 17'h400; ifa.ioctl_rd = 1'b1;
      tick();
      ifa.ioctl_rd = 1'b0;
      check("oor_wait_s1", 32'(ifa.ioctl_wait), 32'h1);
      check("oor_nvrd_s1", 32'(nv_rd_a), 32'h0);
      tick();
      check("oor_wait_s2", 32'(ifa.ioctl_wait), 32'h0);
      check("oor_din", 32'(ifa.ioctl_din), 32'hFF);
      check("oor_nvrd_s2", 32'(nv_rd_a), 32'h0);

      // Wrong index: strobe ignored
      ifa.ioctl_index = 8'd0;
      tick();
      check("wi_busy", 32'(nv_busy_a), 32'h0);
      ifa.ioctl_addr = 17'h003; ifa.ioctl_rd = 1'b1;
      tick();
      ifa.ioctl_rd = 1'b0;
      check("wi_wait", 32'(ifa.ioctl_wait), 32'h0);
      check("wi_nvrd", 32'(nv_rd_a), 32'h0);
      tick();
      check("wi_nvrd2", 32'(nv_rd_a), 32'h0);
      check("wi_din", 32'(ifa.ioctl_din), 32'hFF);
      ifa.ioctl_upload = 1'b0;
      tick();

      // Single write: one pulse 16 cycles after the write
      cpu_we_a = 1'b1; tick(); cpu_we_a = 1'b0;
      pulses = 0; first = 0;
      for (k = 1; k <= 40; k++) begin
         tick();
         if (ifa.ioctl_upload_req === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      check("dr_pulses", 32'(pulses), 32'd1);
      check("dr_delay", 32'(first), 32'd16);

      // Second write at count 10 restarts the quiet period
      cpu_we_a = 1'b1; tick(); cpu_we_a = 1'b0;
      pulses = 0; first = 0;
      repeat (10) begin
         tick();
         if (ifa.ioctl_upload_req === 1'b1) pulses++;
      end
      cpu_we_a = 1'b1; tick(); cpu_we_a = 1'b0;
      for (k = 1; k <= 40; k++) begin
         tick();
         if (ifa.ioctl_upload_req === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      check("dr2_pulses", 32'(pulses), 32'd1);
      check("dr2_delay", 32'(first), 32'd16);

      // Write on the expiry cycle wins
      cpu_we_a = 1'b1; tick(); cpu_we_a = 1'b0;
      repeat (15) tick();
      cpu_we_a = 1'b1; tick(); cpu_we_a = 1'b0;
      check("we_wins_nopulse", 32'(ifa.ioctl_upload_req), 32'h0);
      pulses = 0; first = 0;
      for (k = 1; k <= 40; k++) begin
         tick();
         if (ifa.ioctl_upload_req === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      check("we_wins_delay", 32'(first), 32'd16);

      // Expiry during download is held off until the download ends
      ifa.ioctl_download = 1'b1;
      cpu_we_a = 1'b1; tick(); cpu_we_a = 1'b0;
      pulses = 0;
      repeat (30) begin
         tick();
         if (ifa.ioctl_upload_req === 1'b1) pulses++;
      end
      check("dl_held", 32'(pulses), 32'd0);
      ifa.ioctl_download = 1'b0;
      tick();
      check("dl_pulse", 32'(ifa.ioctl_upload_req), 32'h1);
      tick();
      check("dl_pulse_end", 32'(ifa.ioctl_upload_req), 32'h0);

      // Start of an NVRAM upload clears dirty
      cpu_we_a = 1'b1; tick(); cpu_we_a = 1'b0;
      repeat (3) tick();
      ifa.ioctl_upload = 1'b1; ifa.ioctl_index = 8'd4;
      tick();
      ifa.ioctl_upload = 1'b0;
      pulses = 0;
      repeat (40) begin
         tick();
         if (ifa.ioctl_upload_req === 1'b1) pulses++;
      end
      check("selrise_clear", 32'(pulses), 32'd0);

      // Reset while instance B sits in WAIT_Q
      ifb.ioctl_upload = 1'b1; ifb.ioctl_index = 8'd4;
      tick();
      ifb.ioctl_addr = 17'h007; ifb.ioctl_rd = 1'b1;
      tick();
      ifb.ioctl_rd = 1'b0;
      tick();
      tick();
      check("b_in_waitq", 32'(u_b.state_r), 32'(WAIT_Q));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr_wait", 32'(ifb.ioctl_wait), 32'h0);
      check("mr_busy", 32'(nv_busy_b), 32'h0);
      check("mr_req", 32'(ifb.ioctl_upload_req), 32'h0);
      check("mr_din", 32'(ifb.ioctl_din), 32'h0);
      check("mr_state", 32'(u_b.state_r), 32'(IDLE));
      check("mr_din_a", 32'(ifa.ioctl_din), 32'h0);
      tick();
      ifb.ioctl_addr = 17'h007; ifb.ioctl_rd = 1'b1;
      tick();
      ifb.ioctl_rd = 1'b0;
      n = 0;
      while (ifb.ioctl_wait === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      check("mr_stall", 32'(n), 32'd5);
      check("mr_din_after", 32'(ifb.ioctl_din), 32'({4'h0, mem[7]}));
      ifb.ioctl_upload = 1'b0;

      // Full sweep on A; a pending write is discarded when the upload starts
      cpu_we_a = 1'b1; tick(); cpu_we_a = 1'b0;
      ifa.ioctl_upload = 1'b1; ifa.ioctl_index = 8'd4;
      tick();
      for (int a = 0; a < 1024; a++) begin
         ifa.ioctl_addr = 17'(a); ifa.ioctl_rd = 1'b1;
         tick();
         ifa.ioctl_rd = 1'b0;
         n = 0;
         while (ifa.ioctl_wait === 1'b1 && n < 20) begin
            n++;
            tick();
         end
         check("sweep_din", 32'(ifa.ioctl_din), 32'({4'h0, mem[a]}));
         if (n != 3) check("sweep_stall", 32'(n), 32'd3);
      end
      ifa.ioctl_upload = 1'b0;
      tick();
      check("sweep_dirty", 32'(u_a.u_timer.dirty_r), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nvram_upload_ctrl.md
Name: nvram_upload_ctrl

Overview:
- Reader/responder side of the hps_io file channel; the ROM loader is the existing writer side.
- Serves the game's 4-bit CMOS (high scores, settings) to the HPS during an ioctl upload, stalling hps_io with ioctl_wait while each nibble is fetched.
- Tracks CPU writes to CMOS and raises ioctl_upload_req after a quiet period so the framework saves NVRAM.
- Sits in the emu top between hps_io and the williams2 CMOS read port.

Parameters:
- ADDR_W, 10, CMOS address width (1024 nibbles).
- NV_INDEX, 8'd4, ioctl_index value identifying the NVRAM file.
- RD_LAT, 1, CMOS read latency in clk_sys cycles, from nv_rd to valid nv_q (1..3).
- REQ_DELAY, 24'd4_800_000, quiet cycles after the last CMOS write before a save request (100 ms at 48 MHz).

Ports:
- clk_sys  in  1  system clock (48 MHz)
- reset  in  1  synchronous, active-high reset
- ioctl_upload  in  1  hps_io upload in progress
- ioctl_download  in  1  hps_io download in progress
- ioctl_index  in  8  file index
- ioctl_addr  in  17  byte address of the requested upload byte
- ioctl_rd  in  1  one-cycle read strobe from hps_io
- ioctl_din  out  8  upload data byte
- ioctl_wait  out  1  stall to hps_io
- ioctl_upload_req  out  1  one-cycle save-request pulse
- nv_addr  out  ADDR_W  CMOS read address
- nv_rd  out  1  CMOS read enable, one cycle
- nv_q  in  4  CMOS read data
- cpu_nv_we  in  1  CPU write strobe to CMOS
- nv_busy  out  1  high while an upload of NV_INDEX is active; top muxes the CMOS port to this block

Behaviour:
- Reset state:
  - All outputs 0; FSM IDLE; dirty=0; quiet counter=0.
  - Asserting reset in any state (including mid-fetch) returns to IDLE next cycle and drops ioctl_wait and nv_busy.
- sel = ioctl_upload & (ioctl_index==NV_INDEX). nv_busy = sel, registered with 1-cycle latency.
- Read FSM:
  - IDLE:
    - On ioctl_rd & sel: latch ioctl_addr and set ioctl_wait=1 in the following cycle.
    - If ioctl_addr >= 2**ADDR_W: go to PRESENT with din=8'hFF.
    - Otherwise go to FETCH.
  - FETCH: nv_addr=latched[ADDR_W-1:0], nv_rd=1 for exactly one cycle, then WAIT_Q.
  - WAIT_Q: count RD_LAT cycles, capture din={4'b0000,nv_q}, then PRESENT.
  - PRESENT: ioctl_din updated, ioctl_wait=0 in the same cycle, then IDLE.
  - Total stall for an in-range byte is RD_LAT+2 cycles after the strobe; for an out-of-range byte it is 1 cycle.
  - ioctl_rd is ignored in every state except IDLE (hps_io never issues a strobe while ioctl_wait is high).
  - ioctl_rd without sel is ignored: no wait, ioctl_din holds its value.
  - If sel deasserts mid-fetch, the fetch completes and ioctl_wait then falls; no new fetch starts.
- ioctl_din holds the last presented byte until the next PRESENT.
- Dirty/save logic:
  - cpu_nv_we sets dirty=1 and clears the quiet counter.
  - While dirty and no CMOS write, the counter increments, saturating at REQ_DELAY.
  - When counter==REQ_DELAY & dirty & !ioctl_upload & !ioctl_download: pulse ioctl_upload_req for 1 cycle and clear dirty and counter.
  - If the counter expires while a transfer is active, the request is held off until both ioctl_upload and ioctl_download are low. The pulse fires on the first idle cycle.
  - cpu_nv_we in the same cycle as expiry: the write wins, no pulse, counter restarts at 0.
  - Rising edge of sel clears dirty, because the save is already in progress. A cpu_nv_we during the upload sets dirty again.
  - The counter is 24 bits. REQ_DELAY must fit in 24 bits.

Decomposition:
- Package joust2_nv_pkg holds:
  - rd_state_t enum (IDLE, FETCH, WAIT_Q, PRESENT)
  - NV_INDEX_DEFAULT constant
  - NV_PAD nibble constant 4'b0000
  - OOR_BYTE constant 8'hFF
- One sub-module, nv_dirty_timer, owns the dirty flag, quiet counter, transfer hold-off and request pulse. The read FSM stays in the parent.

Test Plan:
- In-range read, RD_LAT=1: upload, index 4, ioctl_rd at addr 0x005 with CMOS[5]=4'hA.
  - nv_rd with nv_addr=5 one cycle after wait rises.
  - ioctl_din=8'h0A and ioctl_wait=0 on cycle strobe+3.
- Out-of-range read: ioctl_rd at addr 0x400.
  - No nv_rd pulse.
  - ioctl_din=8'hFF; wait high exactly 1 cycle.
- Wrong index: index 0, ioctl_rd pulses.
  - ioctl_wait, nv_rd and nv_busy stay 0; ioctl_din unchanged.
- Dirty request, REQ_DELAY=16: single cpu_nv_we.
  - ioctl_upload_req pulses exactly once, 16 cycles later.
  - A second cpu_nv_we at count 10 delays the pulse to 16 cycles after the second write.
  - Expiry during ioctl_download: pulse on the first cycle after download falls.
- Reset mid-fetch, RD_LAT=3: assert reset in WAIT_Q.
  - Next cycle: ioctl_wait=0, nv_busy=0, ioctl_upload_req=0, ioctl_din=0, FSM IDLE.
  - The next strobe after reset completes normally.
- Full sweep: upload addresses 0..1023 back-to-back with hps_io-style stalls. Every byte equals {4'h0,CMOS[n]}, and dirty is 0 at the end.
